snake_engine: RTL

//  Game-logic core upstream of the splash/title FSM. Holds the snake body, advances it one cell per

---
 rtl/snake_pkg.sv | 24 ++
 rtl/snake_next_head.sv | 44 ++++
 rtl/snake_engine.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared direction encoding and default playfield/length constants for the snake core.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  localparam int unsigned GRID_W_DEF    = 32;
  localparam int unsigned GRID_H_DEF    = 24;
  localparam int unsigned X_W_DEF       = 5;
  localparam int unsigned Y_W_DEF       = 5;
  localparam int unsigned MAX_LEN_DEF   = 16;
  localparam int unsigned START_LEN_DEF = 3;
  localparam int unsigned LEN_W_DEF     = 5;

  // Opposite heading; flipping bit 1 swaps UP<->DOWN and RIGHT<->LEFT.
  function automatic dir_e dir_reverse(input dir_e d);
    return dir_e'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head calculator: one step from the current head, flagging wall exits.
module snake_next_head
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W = GRID_W_DEF,
  parameter int unsigned GRID_H = GRID_H_DEF,
  parameter int unsigned X_W    = X_W_DEF,
  parameter int unsigned Y_W    = Y_W_DEF
) (
  input  logic [X_W-1:0] head_x,
  input  logic [Y_W-1:0] head_y,
  input  dir_e           dir,
  output logic [X_W-1:0] nxt_x,
  output logic [Y_W-1:0] nxt_y,
  output logic           wall_hit
);

  // Step one cell in the requested direction; no wrap-around, edges report a wall hit.
  always_comb begin
    nxt_x    = head_x;
    nxt_y    = head_y;
    wall_hit = 1'b0;
    unique case (dir)
      DIR_UP: begin
        wall_hit = (head_y == '0);
        nxt_y    = head_y - Y_W'(1);
      end
      DIR_RIGHT: begin
        wall_hit = (head_x == X_W'(GRID_W - 1));
        nxt_x    = head_x + X_W'(1);
      end
      DIR_DOWN: begin
        wall_hit = (head_y == Y_W'(GRID_H - 1));
        nxt_y    = head_y + Y_W'(1);
      end
      DIR_LEFT: begin
        wall_hit = (head_x == '0);
        nxt_x    = head_x - X_W'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/snake_engine.sv
// Snake game core: body shift register, direction filter, growth on food, wall/self death.
module snake_engine
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W    = GRID_W_DEF,
  parameter int unsigned GRID_H    = GRID_H_DEF,
  parameter int unsigned X_W       = X_W_DEF,
  parameter int unsigned Y_W       = Y_W_DEF,
  parameter int unsigned MAX_LEN   = MAX_LEN_DEF,
  parameter int unsigned START_LEN = START_LEN_DEF,
  parameter int unsigned LEN_W     = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             enable,
  input  logic             tick,
  input  logic             dir_valid,
  input  logic [1:0]       dir_in,
  input  logic [X_W-1:0]   food_x,
  input  logic [Y_W-1:0]   food_y,
  input  logic [LEN_W-1:0] rd_idx,
  output logic [X_W-1:0]   rd_x,
  output logic [Y_W-1:0]   rd_y,
  output logic             rd_valid,
  output logic [X_W-1:0]   head_x,
  output logic [Y_W-1:0]   head_y,
  output logic [LEN_W-1:0] length,
  output logic             ate,
  output logic             isDead
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [X_W-1:0]   seg_x_q [MAX_LEN];
  logic [X_W-1:0]   seg_x_d [MAX_LEN];
  logic [Y_W-1:0]   seg_y_q [MAX_LEN];
  logic [Y_W-1:0]   seg_y_d [MAX_LEN];
  logic [LEN_W-1:0] length_q, length_d;
  logic             ate_q, ate_d;
  logic             is_dead_q, is_dead_d;
  dir_e             cur_dir_q, cur_dir_d;
  dir_e             pend_dir_q, pend_dir_d;

  dir_e             move_dir;
  logic             key_ok;
  logic             do_move;
  logic [X_W-1:0]   nxt_x;
  logic [Y_W-1:0]   nxt_y;
  logic             wall_hit;
  logic             grow;
  logic [LEN_W-1:0] cmp_lim;
  logic             self_hit;
  logic [IDX_W-1:0] rd_sel;

  snake_next_head #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .X_W    (X_W),
    .Y_W    (Y_W)
  ) u_next_head (
    .head_x   (seg_x_q[0]),
    .head_y   (seg_y_q[0]),
    .dir      (move_dir),
    .nxt_x    (nxt_x),
    .nxt_y    (nxt_y),
    .wall_hit (wall_hit)
  );

  // Direction filter: a key that would reverse the current heading is discarded; a key coinciding
  // with a tick steers that very move.
  always_comb begin
    key_ok     = dir_valid && (dir_e'(dir_in) != dir_reverse(cur_dir_q));
    pend_dir_d = key_ok ? dir_e'(dir_in) : pend_dir_q;
    move_dir   = (key_ok && tick) ? dir_e'(dir_in) : pend_dir_q;
    do_move    = tick && enable && !is_dead_q;
  end

  // Parallel self-collision compare; the tail is excluded unless this move grows the snake.
  always_comb begin
    grow     = (nxt_x == food_x) && (nxt_y == food_y);
    cmp_lim  = grow ? length_q : (length_q - LEN_W'(1));
    self_hit = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < cmp_lim) && (seg_x_q[i] == nxt_x) && (seg_y_q[i] == nxt_y)) begin
        self_hit = 1'b1;
      end
    end
  end

  // Next-state for body, heading, length, ate pulse and sticky death flag.
  always_comb begin
    seg_x_d   = seg_x_q;
    seg_y_d   = seg_y_q;
    cur_dir_d = cur_dir_q;
    length_d  = length_q;
    is_dead_d = is_dead_q;
    ate_d     = 1'b0;
    if (do_move) begin
      if (wall_hit || self_hit) begin
        is_dead_d = 1'b1;
      end else begin
        for (int unsigned i = 1; i < MAX_LEN; i++) begin
          seg_x_d[i] = seg_x_q[i-1];
          seg_y_d[i] = seg_y_q[i-1];
        end
        seg_x_d[0] = nxt_x;
        seg_y_d[0] = nxt_y;
        cur_dir_d  = move_dir;
        if (grow) begin
          ate_d = 1'b1;
          if (length_q != LEN_W'(MAX_LEN)) begin
            length_d = length_q + LEN_W'(1);
          end
        end
      end
    end
  end

  // State registers; rst and restart are equivalent and override everything.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= X_W'(GRID_W / 2 - i);
        seg_y_q[i] <= Y_W'(GRID_H / 2);
      end
      cur_dir_q  <= DIR_RIGHT;
      pend_dir_q <= DIR_RIGHT;
      length_q   <= LEN_W'(START_LEN);
      ate_q      <= 1'b0;
      is_dead_q  <= 1'b0;
    end else begin
      seg_x_q    <= seg_x_d;
      seg_y_q    <= seg_y_d;
      cur_dir_q  <= cur_dir_d;
      pend_dir_q <= pend_dir_d;
      length_q   <= length_d;
      ate_q      <= ate_d;
      is_dead_q  <= is_dead_d;
    end
  end

  assign rd_sel   = rd_idx[IDX_W-1:0];
  assign rd_x     = seg_x_q[rd_sel];
  assign rd_y     = seg_y_q[rd_sel];
  assign rd_valid = (rd_idx < length_q);
  assign head_x   = seg_x_q[0];
  assign head_y   = seg_y_q[0];
  assign length   = length_q;
  assign ate      = ate_q;
  assign isDead   = is_dead_q;

endmodule
